// File: rtl/loader_pkg.sv
// Shared types and defaults for the program loader (LOAD/RUN encoding, NOP word).
package loader_pkg;

  localparam int unsigned INSTR_W                 = 8;
  localparam int unsigned DEFAULT_DEPTH           = 32;
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 250000;

  // Jump +0: a harmless instruction for unprogrammed or out-of-range fetches.
  localparam logic [INSTR_W-1:0] NOP_INSTR = 8'hC0;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/button_debouncer.sv
// Load-button conditioning: 2-flop synchronizer, optional debounce, rising-edge pulse.
// Debounce filter is built only when LOADER_DEBOUNCE_EN is defined.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic press_o
);

  if (DEBOUNCE_CYCLES < 1) begin : g_cfg_err
    $error("button_debouncer: DEBOUNCE_CYCLES must be at least 1");
  end

  logic [1:0] sync_q;
  logic       level;
  logic       prev_q;
  logic       press_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sync_q <= '0;
    else       sync_q <= {sync_q[0], btn_i};
  end

`ifdef LOADER_DEBOUNCE_EN
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          stable_q, stable_d;

  // Any sample equal to the accepted level restarts the run of differing samples.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (sync_q[1] != stable_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) stable_d = sync_q[1];
      else                                   cnt_d    = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign level = stable_q;
`else
  assign level = sync_q[1];
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_q  <= 1'b0;
      press_q <= 1'b0;
    end else begin
      prev_q  <= level;
      press_q <= level & ~prev_q;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/program_loader.sv
// Front-panel program loader: switches write instruction words in LOAD, CPU fetches in RUN.
// Define LOADER_DEBOUNCE_EN to debounce load_button before edge detection.
module program_loader
  import loader_pkg::*;
#(
  parameter int unsigned DEPTH           = DEFAULT_DEPTH,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic               oscillator,
  input  logic               reset,
  input  logic               run_switch,
  input  logic               load_button,
  input  logic [INSTR_W-1:0] data_switches,
  input  logic [7:0]         instruction_address,
  output logic [INSTR_W-1:0] instruction,
  output logic               cpu_reset,
  output logic [4:0]         load_ptr,
  output logic [INSTR_W-1:0] echo,
  output logic               full,
  output logic               running
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (DEPTH < 1 || DEPTH > 32) begin : g_cfg_err
    $error("program_loader: DEPTH must be in 1..32 to fit load_ptr");
  end

  state_e             state_q, state_d;
  logic [1:0]         run_sync_q;
  logic               press;
  logic               wr_en;
  logic [AW-1:0]      ptr_q, ptr_d;
  logic [INSTR_W-1:0] echo_q, echo_d;
  logic               full_q, full_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [INSTR_W-1:0] mem_q [DEPTH];

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_load_btn (
    .clk_i  (oscillator),
    .rst_i  (reset),
    .btn_i  (load_button),
    .press_o(press)
  );

  always_ff @(posedge oscillator or posedge reset) begin
    if (reset) run_sync_q <= '0;
    else       run_sync_q <= {run_sync_q[0], run_switch};
  end

  // A press is taken only while staying in LOAD, so one racing the RUN request is dropped.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    echo_d  = echo_q;
    full_d  = full_q;
    instr_d = NOP_INSTR;
    wr_en   = 1'b0;
    case (state_q)
      ST_LOAD: begin
        if (run_sync_q[1]) begin
          state_d = ST_RUN;
        end else if (press && !full_q) begin
          wr_en  = 1'b1;
          echo_d = data_switches;
          if (ptr_q == AW'(DEPTH - 1)) begin
            ptr_d  = '0;
            full_d = 1'b1;
          end else begin
            ptr_d = ptr_q + AW'(1);
          end
        end
      end
      ST_RUN: begin
        if (!run_sync_q[1]) state_d = ST_LOAD;
        if (instruction_address < 8'(DEPTH))
          instr_d = mem_q[instruction_address[AW-1:0]];
      end
    endcase
  end

  always_ff @(posedge oscillator or posedge reset) begin
    if (reset) begin
      state_q <= ST_LOAD;
      ptr_q   <= '0;
      echo_q  <= '0;
      full_q  <= 1'b0;
      instr_q <= NOP_INSTR;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      echo_q  <= echo_d;
      full_q  <= full_d;
      instr_q <= instr_d;
    end
  end

  always_ff @(posedge oscillator or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= NOP_INSTR;
    end else if (wr_en) begin
      mem_q[ptr_q] <= data_switches;
    end
  end

  assign instruction = instr_q;
  assign load_ptr    = 5'(ptr_q);
  assign echo        = echo_q;
  assign full        = full_q;
  assign cpu_reset   = reset | (state_q == ST_LOAD);
  assign running     = (state_q == ST_RUN);

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: load/run tables plus corner-case sequences.
module tb_program_loader;
  import loader_pkg::*;

  logic       oscillator = 1'b0;
  logic       reset;
  logic       run_switch;
  logic       load_button;
  logic [7:0] data_switches;
  logic [7:0] instruction_address;
  logic [7:0] instruction;
  logic       cpu_reset;
  logic [4:0] load_ptr;
  logic [7:0] echo;
  logic       full;
  logic       running;

  always #5 oscillator = ~oscillator;

  program_loader #(
    .DEPTH          (32),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .oscillator         (oscillator),
    .reset              (reset),
    .run_switch         (run_switch),
    .load_button        (load_button),
    .data_switches      (data_switches),
    .instruction_address(instruction_address),
    .instruction        (instruction),
    .cpu_reset          (cpu_reset),
    .load_ptr           (load_ptr),
    .echo               (echo),
    .full               (full),
    .running            (running)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] data;
    logic [7:0] exp_echo;
    logic [4:0] exp_ptr;
    logic       exp_full;
  } ld_t;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] exp_instr;
  } rd_t;

  logic [7:0] expq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge oscillator);
  endtask

  task automatic press(input logic [7:0] d);
    data_switches = d;
    load_button   = 1'b1;
    cyc(10);
    load_button   = 1'b0;
    cyc(10);
  endtask

  task automatic set_run(input logic r);
    run_switch = r;
    cyc(5);
  endtask

  // Expected word is queued as the address is driven and popped when the registered read lands.
  task automatic do_reads(input rd_t t[$]);
    foreach (t[i]) begin
      instruction_address = t[i].addr;
      expq.push_back(t[i].exp_instr);
      cyc(1);
      chk($sformatf("rd_addr_%0d", t[i].addr), instruction, expq.pop_front());
    end
  endtask

  task automatic do_loads(input ld_t t[$]);
    foreach (t[i]) begin
      press(t[i].data);
      chk($sformatf("ld%0d_echo", i), echo, t[i].exp_echo);
      chk($sformatf("ld%0d_ptr", i), load_ptr, t[i].exp_ptr);
      chk($sformatf("ld%0d_full", i), full, t[i].exp_full);
    end
  endtask

  initial begin
    ld_t loads[$];
    rd_t reads[$];

    loads = '{'{8'h14, 8'h14, 5'd1, 1'b0},
              '{8'h3A, 8'h3A, 5'd2, 1'b0},
              '{8'hC1, 8'hC1, 5'd3, 1'b0}};

    reset = 1'b1; run_switch = 1'b0; load_button = 1'b0;
    data_switches = 8'h00; instruction_address = 8'h00;
    cyc(2);
    chk("rst_cpu_reset", cpu_reset, 1'b1);
    chk("rst_running", running, 1'b0);
    chk("rst_ptr", load_ptr, 5'd0);
    chk("rst_full", full, 1'b0);
    chk("rst_echo", echo, 8'h00);
    chk("rst_instr", instruction, 8'hC0);
    reset = 1'b0;
    cyc(2);

    do_loads(loads);
    chk("load_cpu_reset", cpu_reset, 1'b1);
    chk("load_instr", instruction, 8'hC0);
    chk("load_running", running, 1'b0);

    set_run(1'b1);
    chk("run_running", running, 1'b1);
    chk("run_cpu_reset", cpu_reset, 1'b0);
    reads = '{'{8'd0, 8'h14}, '{8'd1, 8'h3A}, '{8'd2, 8'hC1}, '{8'd40, 8'hC0},
              '{8'd3, 8'hC0}, '{8'd31, 8'hC0}, '{8'd32, 8'hC0}};
    do_reads(reads);

    press(8'h77);
    chk("runpress_echo", echo, 8'hC1);
    chk("runpress_ptr", load_ptr, 5'd3);
    reads = '{'{8'd3, 8'hC0}, '{8'd2, 8'hC1}};
    do_reads(reads);

    set_run(1'b0);
    chk("reload_running", running, 1'b0);
    chk("reload_ptr", load_ptr, 5'd3);
    chk("reload_echo", echo, 8'hC1);
    chk("reload_full", full, 1'b0);
    chk("reload_instr", instruction, 8'hC0);

`ifndef LOADER_DEBOUNCE_EN
    // Button leads the RUN request by one cycle so its pulse arrives on the switch-over cycle.
    data_switches = 8'h66;
    load_button   = 1'b1;
    cyc(1);
    run_switch    = 1'b1;
    cyc(8);
    load_button   = 1'b0;
    cyc(5);
    chk("race_ptr", load_ptr, 5'd3);
    chk("race_echo", echo, 8'hC1);
    chk("race_running", running, 1'b1);
    reads = '{'{8'd3, 8'hC0}, '{8'd0, 8'h14}};
    do_reads(reads);
    set_run(1'b0);
`else
    data_switches = 8'h5A;
    for (int i = 0; i < 10; i++) begin
      load_button = (i % 2 == 0);
      cyc(2);
    end
    load_button = 1'b1;
    cyc(20);
    load_button = 1'b0;
    cyc(20);
    chk("bounce_ptr", load_ptr, 5'd4);
    chk("bounce_echo", echo, 8'h5A);
`endif

    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(2);
    for (int i = 0; i < 32; i++) begin
      press(8'h55);
      if (i == 30) begin
        chk("fill31_ptr", load_ptr, 5'd31);
        chk("fill31_full", full, 1'b0);
      end
    end
    chk("full_flag", full, 1'b1);
    chk("full_ptr", load_ptr, 5'd0);
    chk("full_echo", echo, 8'h55);
    press(8'hAA);
    chk("over_echo", echo, 8'h55);
    chk("over_ptr", load_ptr, 5'd0);
    chk("over_full", full, 1'b1);
    set_run(1'b1);
    reads = '{'{8'd0, 8'h55}, '{8'd31, 8'h55}, '{8'd15, 8'h55}};
    do_reads(reads);

    #2 reset = 1'b1;
    #1;
    chk("midrun_running", running, 1'b0);
    chk("midrun_cpu_reset", cpu_reset, 1'b1);
    chk("midrun_ptr", load_ptr, 5'd0);
    chk("midrun_full", full, 1'b0);
    chk("midrun_echo", echo, 8'h00);
    chk("midrun_instr", instruction, 8'hC0);
    cyc(1);
    reset = 1'b0;
    cyc(5);
    chk("rerun_running", running, 1'b1);
    chk("rerun_ptr", load_ptr, 5'd0);
    reads = '{'{8'd0, 8'hC0}, '{8'd5, 8'hC0}, '{8'd31, 8'hC0}};
    do_reads(reads);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter DEPTH, default 32, number of 8-bit instruction words held.
REQ-002 Parameter DEBOUNCE_CYCLES, default 250000, stable oscillator cycles required to accept a button level.
REQ-003 oscillator  input  1  single clock for all state; rising edge active.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 run_switch  input  1  asynchronous switch; 1 = RUN requested, 0 = LOAD requested.
REQ-006 load_button  input  1  asynchronous push button; each accepted press writes one word.
REQ-007 data_switches  input  8  instruction word to write on a press.
REQ-008 instruction_address  input  8  processor PC (fetch address).
REQ-009 instruction  output  8  fetched word for the processor.
REQ-010 cpu_reset  output  1  holds the processor in reset while loading.
REQ-011 load_ptr  output  5  next write address.
REQ-012 echo  output  8  last word written.
REQ-013 full  output  1  all DEPTH words written.
REQ-014 running  output  1  1 in RUN state.

Function
REQ-015 States: LOAD and RUN; the state register, memory, load_ptr, echo, full and instruction all update on the oscillator rising edge.
REQ-016 run_switch and load_button each pass through a 2-flop synchronizer before use.
REQ-017 LOAD->RUN when the synchronized run_switch is 1; RUN->LOAD when it is 0; one cycle per transition.
REQ-018 A press is the rising edge of the conditioned load_button, one cycle wide, and is acted on only in LOAD.
REQ-019 Press in LOAD with full=0: mem[load_ptr] <= data_switches, echo <= data_switches, load_ptr <= load_ptr+1.
REQ-020 The press at load_ptr=DEPTH-1 sets full=1 and wraps load_ptr to 0.
REQ-021 Presses while full=1 are ignored: no write, and load_ptr and echo are unchanged.
REQ-022 Presses in RUN are ignored.
REQ-023 A press coincident with the LOAD->RUN transition is ignored.
REQ-024 Re-entering LOAD from RUN preserves memory, load_ptr and full.
REQ-025 RUN read: instruction <= mem[instruction_address] when instruction_address < DEPTH, else 8'hC0 (jump +0, a NOP); latency is one oscillator cycle.
REQ-026 In LOAD, instruction is registered 8'hC0.
REQ-027 cpu_reset = reset OR (state==LOAD), combinational.
REQ-028 running = (state==RUN), combinational.

Reset
REQ-029 Reset asserted: state=LOAD, load_ptr=0, full=0, echo=8'h00, instruction=8'hC0, synchronizer and debounce flops cleared, and every memory word set to 8'hC0.
REQ-030 Reset asserted mid-press or mid-RUN aborts the operation immediately; no partial write is retained.

Configuration
REQ-031 With LOADER_DEBOUNCE_EN defined, load_button is accepted only after DEBOUNCE_CYCLES consecutive equal synchronized samples before edge detection.
REQ-032 Without LOADER_DEBOUNCE_EN, the edge detector uses the synchronized button directly; DEBOUNCE_CYCLES is unused.

Structure
REQ-033 Shared package loader_pkg holds: the LOAD/RUN state encoding, NOP_INSTR=8'hC0, the default DEPTH, and the default DEBOUNCE_CYCLES.
REQ-034 Synchronizer, optional debounce and rising-edge pulse live in sub-module button_debouncer, instantiated once for load_button; run_switch uses a bare synchronizer.

Verification
REQ-035 Reset, run_switch=0, then presses of 8'h14, 8'h3A, 8'hC1 -> echo=8'hC1, load_ptr=3, full=0, cpu_reset=1, instruction=8'hC0.
REQ-036 After REQ-035, run_switch=1, instruction_address 0,1,2,40 -> instruction 8'h14, 8'h3A, 8'hC1, 8'hC0, each one cycle after the address; running=1, cpu_reset=0.
REQ-037 32 presses of 8'h55 -> full=1, load_ptr=0; a 33rd press of 8'hAA leaves mem[0]=8'h55 and echo=8'h55.
REQ-038 LOADER_DEBOUNCE_EN with DEBOUNCE_CYCLES=4: button bouncing 0/1 every 2 cycles for 20 cycles, then held high -> exactly one write.
REQ-039 Press in RUN -> no change to memory, load_ptr or echo; reset pulse mid-RUN -> state LOAD, load_ptr=0, all words read 8'hC0 after returning to RUN.
